mixcolumn_serial: RTL and testbench
===================================

# mixcolumn_serial

Byte-serial AES MixColumns stage for the low-area datapath, sitting directly downstream of the byte-serial ShiftRows stage. It consumes the 16 shifted state bytes one per cycle in column-major order, assembles each 4-byte column, and applies the MixColumns matrix. It then emits the four mixed bytes one per cycle, so sustained throughput stays at one byte per clock. A per-column bypass passes bytes through unchanged for the final AES round.

## Interface
- No parameters; the datapath width is fixed at 8 bits.
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- din  in  8  ShiftRows output byte; row r of the current column, r = 0..3 in order.
- din_valid  in  1  din carries a valid byte this cycle.
- last_round  in  1  bypass request; sampled with row 0 of each column.
- inv  in  1  inverse MixColumns request; sampled with row 0 of each column. Honoured only under MIXCOL_INV_EN.
- dout  out  8  mixed byte, row order 0..3.
- dout_valid  out  1  dout is valid.
- dout_last  out  1  high with row 3 of each output column.

## Operation
- Input side: 2-bit row counter `in_cnt`, advancing only when din_valid=1. Bytes a0..a2 go into a 3-byte capture register.
- last_round and inv are latched when din_valid=1 and in_cnt=0. They hold for that column, and later changes within the column are ignored.
- On the edge where din_valid=1 and in_cnt=3, the 4-byte output register is loaded from {a0,a1,a2,din}, the output counter `out_cnt` is set to 0, and in_cnt wraps to 0.
- Gaps in din_valid: in_cnt holds and partial column contents are kept. Gaps of any length are legal.
- Forward transform:
  - b0 = 2a0^3a1^a2^a3
  - b1 = a0^2a1^3a2^a3
  - b2 = a0^a1^2a2^3a3
  - b3 = 3a0^a1^a2^2a3
- Arithmetic is GF(2^8). xtime(x) = {x[6:0],0} ^ (x[7] ? 8'h1b : 0), and 3x = xtime(x)^x.
- Bypass (latched last_round=1): b_r = a_r.
- Output side: after a load, the output register drains over exactly 4 cycles, b0 first.
  - dout_valid=1 for all 4 cycles; dout_last=1 on the b3 cycle only.
  - Output does not stall and there is no backpressure.
- Simultaneous load and drain: a new column completes no earlier than the cycle in which b3 of the previous column is presented. A load on that edge is legal, and the next cycle shows the new b0 with no bubble.
- Outputs when idle (nothing to drain): dout=8'h00, dout_valid=0, dout_last=0.
- Reset, asserted at any time including mid-column or mid-drain:
  - in_cnt=0, out_cnt idle, all capture and output registers 8'h00, latched flags 0.
  - Partial columns are discarded.
  - dout=8'h00, dout_valid=0, dout_last=0 immediately (asynchronous).

## Timing
- Latency: byte a0 accepted at cycle t (rows contiguous) gives b0 on dout at cycle t+4, and b3 at t+7. Outputs are registered.
- If the input has gaps, latency is measured from the cycle a3 is accepted: b0 appears the following cycle.
- Throughput: one byte per cycle sustained; 16 cycles per AES state.
- Combinational path: din through the xtime/XOR network into the output register. No combinational path from inputs to outputs.

## Configuration
- MIXCOL_INV_EN:
  - Defined: when latched inv=1 and last_round=0, the column is transformed by InvMixColumns with coefficients {0e,0b,0d,09}, rotated per row:
    - b0 = 0e·a0^0b·a1^0d·a2^09·a3
    - b1, b2, b3 follow by rotating the coefficient row.
  - Defined, with inv=1 and last_round=1: bypass takes priority.
  - Undefined: the inv port remains present but is ignored. No inverse multiplier logic is synthesised, and behaviour equals inv=0.

## Test plan
- Forward vector: rst_n released, din = db,13,53,45 on 4 consecutive cycles -> dout = 8e,4d,a1,bc at cycles t+4..t+7, with dout_last on bc.
- Back-to-back columns: f2,0a,22,5c then 2d,26,31,4c contiguously -> 9f,dc,58,9d,4d,7e,bd,f8 with no gap in dout_valid. Also check c6,c6,c6,c6 -> c6,c6,c6,c6.
- Gapped input with bypass: d4,(gap 3 cycles),d4,d4,d5 with last_round=1 at row 0 (then toggled to 0 mid-column) -> d4,d4,d4,d5 starting the cycle after d5 is accepted.
- Reset mid-operation: assert rst_n=0 after 2 bytes of a column and during a drain -> dout_valid=0 and dout=00 immediately. After release, the next full column db,13,53,45 -> 8e,4d,a1,bc (stale bytes not mixed in).
- MIXCOL_INV_EN defined, inv=1: 8e,4d,a1,bc -> db,13,53,45. Same stimulus with the macro undefined -> forward result of that input.
- Full 16-byte state from FIPS-197 round 1 (after ShiftRows: d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5) -> 04 66 81 e5 e0 cb 19 9a 48 f8 d3 7a 28 06 26 4c.

Source files
------------

// File: rtl/mixcolumn_serial.sv
// ---------------------------------------------------------------------------
// mixcolumn_serial
//
// Byte-serial AES MixColumns stage. Takes ShiftRows output one byte per clock
// in column-major order (row 0..3). Rows 0..2 go into a capture register.
// When row 3 arrives, the whole column is mixed in one combinational step
// and loaded into the output register. The output register then drains
// b0..b3 over the next four cycles, so throughput stays at one byte per clock.
//
// Optional feature macro: MIXCOL_INV_EN
//   When defined, a column whose latched inv=1 (and last_round=0) uses
//   InvMixColumns. When undefined, inv is ignored and no inverse multipliers
//   are built.
//
// Ports:
//   clk         in   1  rising-edge clock
//   rst_n       in   1  asynchronous active-low reset
//   din         in   8  ShiftRows byte, row order 0..3 within a column
//   din_valid   in   1  din carries a valid byte
//   last_round  in   1  bypass request, latched with row 0
//   inv         in   1  inverse request, latched with row 0 (MIXCOL_INV_EN)
//   dout        out  8  mixed byte, row order 0..3 (8'h00 when idle)
//   dout_valid  out  1  dout is valid
//   dout_last   out  1  high with row 3 of each output column
// ---------------------------------------------------------------------------
module mixcolumn_serial (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] din,
    input  logic       din_valid,
    input  logic       last_round,
    input  logic       inv,
    output logic [7:0] dout,
    output logic       dout_valid,
    output logic       dout_last
);

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

`ifdef MIXCOL_INV_EN
    // InvMixColumns coefficients built from x, 2x, 4x and 8x.
    function automatic logic [7:0] mul09(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ x;
    endfunction

    function automatic logic [7:0] mul0b(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(x) ^ x;
    endfunction

    function automatic logic [7:0] mul0d(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ x;
    endfunction

    function automatic logic [7:0] mul0e(input logic [7:0] x);
        return xtime(xtime(xtime(x))) ^ xtime(xtime(x)) ^ xtime(x);
    endfunction
`endif

    logic [1:0]      in_cnt;
    logic [2:0][7:0] cap_q;
    logic            lr_q;
    logic [2:0][7:0] hold_q;     // b1..b3 waiting behind dout
    logic [1:0]      out_cnt;    // row currently presented on dout

    logic            load;
    logic [7:0]      a0, a1, a2, a3;
    logic [7:0]      x0, x1, x2, x3;
    logic [7:0]      b0, b1, b2, b3;

`ifdef MIXCOL_INV_EN
    logic            inv_q;
`else
    logic            unused_inv;
    assign unused_inv = inv;
`endif

    assign load = din_valid && (in_cnt == 2'd3);

    // Row 3 is never registered on the input side. It is mixed straight
    // from din on the load edge.
    assign a0 = cap_q[0];
    assign a1 = cap_q[1];
    assign a2 = cap_q[2];
    assign a3 = din;

    assign x0 = xtime(a0);
    assign x1 = xtime(a1);
    assign x2 = xtime(a2);
    assign x3 = xtime(a3);

    always_comb begin
        b0 = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
        b1 = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
        b2 = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
        b3 = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
        if (lr_q) begin
            b0 = a0;
            b1 = a1;
            b2 = a2;
            b3 = a3;
        end
`ifdef MIXCOL_INV_EN
        else if (inv_q) begin
            b0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
            b1 = mul09(a0) ^ mul0e(a1) ^ mul0b(a2) ^ mul0d(a3);
            b2 = mul0d(a0) ^ mul09(a1) ^ mul0e(a2) ^ mul0b(a3);
            b3 = mul0b(a0) ^ mul0d(a1) ^ mul09(a2) ^ mul0e(a3);
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt     <= 2'd0;
            cap_q      <= '0;
            lr_q       <= 1'b0;
`ifdef MIXCOL_INV_EN
            inv_q      <= 1'b0;
`endif
            hold_q     <= '0;
            out_cnt    <= 2'd0;
            dout       <= 8'h00;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            // Input side: the counter and capture register hold across gaps.
            if (din_valid) begin
                in_cnt <= in_cnt + 2'd1;
                case (in_cnt)
                    2'd0: begin
                        cap_q[0] <= din;
                        lr_q     <= last_round;
`ifdef MIXCOL_INV_EN
                        inv_q    <= inv;
`endif
                    end
                    2'd1:    cap_q[1] <= din;
                    2'd2:    cap_q[2] <= din;
                    default: ;
                endcase
            end

            // Output side: a load takes priority over draining. It may land
            // on the b3 cycle of the previous column, which leaves no bubble.
            if (load) begin
                dout       <= b0;
                hold_q     <= {b3, b2, b1};
                out_cnt    <= 2'd0;
                dout_valid <= 1'b1;
                dout_last  <= 1'b0;
            end else if (dout_valid) begin
                case (out_cnt)
                    2'd0: begin
                        dout      <= hold_q[0];
                        out_cnt   <= 2'd1;
                        dout_last <= 1'b0;
                    end
                    2'd1: begin
                        dout      <= hold_q[1];
                        out_cnt   <= 2'd2;
                        dout_last <= 1'b0;
                    end
                    2'd2: begin
                        dout      <= hold_q[2];
                        out_cnt   <= 2'd3;
                        dout_last <= 1'b1;
                    end
                    default: begin
                        dout       <= 8'h00;
                        out_cnt    <= 2'd0;
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mixcolumn_serial.sv
// ---------------------------------------------------------------------------
// tb_mixcolumn_serial
//
// Directed bench for mixcolumn_serial. Inputs change on the falling edge.
// Outputs are compared on the same falling edge, which is half a cycle after
// the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_mixcolumn_serial;

    logic       clk;
    logic       rst_n;
    logic [7:0] din;
    logic       din_valid;
    logic       last_round;
    logic       inv;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;

    int checks = 0;
    int errors = 0;

`ifdef MIXCOL_INV_EN
    localparam logic [31:0] INV_EXP = 32'hdb135345;
`else
    localparam logic [31:0] INV_EXP = 32'hcd504506;   // forward mix of 8e4da1bc
`endif

    mixcolumn_serial dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .last_round (last_round),
        .inv        (inv),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] d, input logic v, input logic l);
        checks++;
        assert ({dout, dout_valid, dout_last} === {d, v, l})
        else begin
            errors++;
            $error("FAIL %s: got dout=%h valid=%b last=%b, want dout=%h valid=%b last=%b",
                   tag, dout, dout_valid, dout_last, d, v, l);
        end
    endtask

    task automatic drive(input logic [7:0] b, input logic v, input logic lr, input logic iv);
        @(negedge clk);
        din        = b;
        din_valid  = v;
        last_round = lr;
        inv        = iv;
    endtask

    task automatic col4(input logic [31:0] a, input logic lr, input logic iv);
        for (int r = 0; r < 4; r++)
            drive(a[31-8*r -: 8], 1'b1, lr, iv);
    endtask

    // Feeds a new column while checking the previous column's drain.
    task automatic col4_chk(input logic [31:0] a, input logic lr, input logic iv,
                            input string tag, input logic [31:0] b);
        for (int r = 0; r < 4; r++) begin
            drive(a[31-8*r -: 8], 1'b1, lr, iv);
            chk($sformatf("%s_b%0d", tag, r), b[31-8*r -: 8], 1'b1, r == 3);
        end
    endtask

    task automatic expect4(input string tag, input logic [31:0] b);
        for (int r = 0; r < 4; r++) begin
            drive(8'h00, 1'b0, 1'b0, 1'b0);
            chk($sformatf("%s_b%0d", tag, r), b[31-8*r -: 8], 1'b1, r == 3);
        end
    endtask

    task automatic idle(input string tag);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        chk(tag, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n      = 1'b0;
        din        = 8'h00;
        din_valid  = 1'b0;
        last_round = 1'b0;
        inv        = 1'b0;
        #3;
        chk("reset_idle", 8'h00, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle("post_reset_idle");

        // Basic forward column. a0 is sampled at cycle t and b0 appears at t+4.
        col4(32'hdb135345, 1'b0, 1'b0);
        expect4("fwd", 32'h8e4da1bc);
        idle("fwd_idle");

        // Back-to-back columns with no gap in dout_valid.
        col4(32'hf20a225c, 1'b0, 1'b0);
        col4_chk(32'h2d26314c, 1'b0, 1'b0, "b2b0", 32'h9fdc589d);
        col4_chk(32'hc6c6c6c6, 1'b0, 1'b0, "b2b1", 32'h4d7ebdf8);
        expect4("b2b2", 32'hc6c6c6c6);
        idle("b2b_idle");

        // Gapped bypass column. last_round drops mid-column and is ignored.
        drive(8'hd4, 1'b1, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            drive(8'hff, 1'b0, 1'b1, 1'b0);
            chk($sformatf("gap%0d", g), 8'h00, 1'b0, 1'b0);
        end
        drive(8'hd4, 1'b1, 1'b0, 1'b0);
        drive(8'hd4, 1'b1, 1'b0, 1'b0);
        drive(8'hd5, 1'b1, 1'b0, 1'b0);
        expect4("byp", 32'hd4d4d4d5);
        idle("byp_idle");

        // Reset during a drain, with a partial column in flight.
        col4(32'hdb135345, 1'b0, 1'b0);
        drive(8'hf2, 1'b1, 1'b0, 1'b0);
        chk("rst_pre_b0", 8'h8e, 1'b1, 1'b0);
        drive(8'h0a, 1'b1, 1'b0, 1'b0);
        chk("rst_pre_b1", 8'h4d, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1 chk("rst_async", 8'h00, 1'b0, 1'b0);
        drive(8'h22, 1'b1, 1'b0, 1'b0);
        chk("rst_held", 8'h00, 1'b0, 1'b0);
        drive(8'h00, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        col4(32'hdb135345, 1'b0, 1'b0);
        expect4("post_rst", 32'h8e4da1bc);
        idle("post_rst_idle");

        // Inverse request. The result depends on the build.
        col4(32'h8e4da1bc, 1'b0, 1'b1);
        expect4("inv", INV_EXP);
        // inv is only sampled with row 0, so this column is a forward mix.
        drive(8'h8e, 1'b1, 1'b0, 1'b0);
        drive(8'h4d, 1'b1, 1'b0, 1'b1);
        drive(8'ha1, 1'b1, 1'b0, 1'b1);
        drive(8'hbc, 1'b1, 1'b0, 1'b1);
        expect4("inv_late", 32'hcd504506);
        // Bypass wins over inverse.
        col4(32'h8e4da1bc, 1'b1, 1'b1);
        expect4("inv_byp", 32'h8e4da1bc);
        idle("inv_idle");

        // Full FIPS-197 round-1 state.
        col4(32'hd4bf5d30, 1'b0, 1'b0);
        col4_chk(32'he0b452ae, 1'b0, 1'b0, "fips0", 32'h046681e5);
        col4_chk(32'hb84111f1, 1'b0, 1'b0, "fips1", 32'he0cb199a);
        col4_chk(32'h1e2798e5, 1'b0, 1'b0, "fips2", 32'h48f8d37a);
        expect4("fips3", 32'h2806264c);
        idle("fips_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
